// File: rtl/dsp_ctrl_pkg.sv
// Shared definitions for the dsp MAC sequencer: OPMODE encodings, FSM states,
// the operand tag carried alongside the dsp pipeline, and bus widths.
package dsp_ctrl_pkg;

  localparam int OPND_W = 18;
  localparam int ACC_W  = 48;

  // Bit 0 selects X=M, bit 3 selects Z=P; the adder, carry and pre-adder stay at defaults.
  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_HOLD  = 8'h08;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic valid;
    logic first;
  } tag_t;

  function automatic logic [7:0] tag_to_opmode(input tag_t tag);
    if (!tag.valid) begin
      return OPM_HOLD;
    end
    return tag.first ? OPM_FIRST : OPM_ACC;
  endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Operand and result streams of the MAC sequencer; the sequencer is the slave
// on both (sink for operands, source for results).
interface dsp_mac_sequencer_if;
  import dsp_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OPND_W-1:0] in_a;
  logic [OPND_W-1:0] in_b;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;

  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data
  );

endinterface

// File: rtl/dsp_seq_tag_pipe.sv
// Delays each operand tag so its OPMODE lines up with the product it describes
// inside the dsp; a flush empties the pipe so no stale term reaches the adder.
module dsp_seq_tag_pipe
  import dsp_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives one dsp slice as a multiply-accumulate engine: streams operand pairs
// into A/B, sequences OPMODE in step with the dsp pipeline and returns the sum.
module dsp_mac_sequencer
  import dsp_ctrl_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int OPM_DLY = 2,
  parameter int RES_DLY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic                abort,
  output logic                busy,
  dsp_mac_sequencer_if.slave  bus,
  output logic [OPND_W-1:0]   dsp_a,
  output logic [OPND_W-1:0]   dsp_b,
  output logic [7:0]          dsp_opmode,
  output logic                dsp_rstp,
  input  logic [ACC_W-1:0]    dsp_p
);

  localparam int DRAIN_CYC = OPM_DLY + RES_DLY;
  localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC);

  state_t             state;
  state_t             state_next;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   count;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               accept;
  logic               job_start;
  logic               job_abort;
  logic               last_term;
  logic               capture;
  tag_t               tag_in;
  tag_t               tag_out;

  // An abort cancels the job outright, so a pair offered in that cycle is dropped.
  assign accept    = (state == ISSUE) && bus.in_valid && !abort;
  assign job_start = (state == IDLE) && start && (len != '0);
  assign job_abort = (state != IDLE) && abort;
  assign last_term = accept && (count == len_q - LEN_W'(1));
  assign capture   = (state == DRAIN) && (drain_cnt == DRAIN_LAST) && !abort;

  assign busy          = (state != IDLE);
  assign bus.in_ready  = (state == ISSUE);
  assign bus.res_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tag_in     = '0;
    if (accept) begin
      tag_in.valid = 1'b1;
      tag_in.first = (count == '0);
    end
    unique case (state)
      IDLE:    if (job_start) state_next = ISSUE;
      ISSUE:   if (abort) state_next = IDLE;
               else if (last_term) state_next = DRAIN;
      DRAIN:   if (abort) state_next = IDLE;
               else if (capture) state_next = DONE;
      DONE:    if (abort || bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      count        <= '0;
      drain_cnt    <= '0;
      dsp_a        <= '0;
      dsp_b        <= '0;
      dsp_rstp     <= 1'b0;
      bus.res_data <= '0;
    end else begin
      dsp_rstp <= job_start || job_abort;
      dsp_a    <= accept ? bus.in_a : '0;
      dsp_b    <= accept ? bus.in_b : '0;
      if (job_start) begin
        len_q <= len;
        count <= '0;
      end else if (accept) begin
        count <= count + LEN_W'(1);
      end
      // Counts from the first DRAIN cycle; dsp_p is final on the last one.
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + DRAIN_W'(1);
      end else begin
        drain_cnt <= '0;
      end
      if (capture) begin
        bus.res_data <= dsp_p;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_opmode <= OPM_HOLD;
    end else if (job_abort) begin
      dsp_opmode <= OPM_HOLD;
    end else begin
      dsp_opmode <= tag_to_opmode(tag_out);
    end
  end

  dsp_seq_tag_pipe #(
    .DEPTH (OPM_DLY)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (job_abort),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Controller that drives one dsp instance as a multiply-accumulate engine.
- Accepts a job of `len` operand pairs over a valid/ready stream and feeds them to the dsp A/B ports.
- Issues the OPMODE sequence aligned to the dsp pipeline: first term P=M, later terms P=P+M, bubbles P=P+0.
- Captures the final P and presents it on a valid/ready result port. Sits between the operand source (FIR/dot-product front end) and the dsp datapath.

Parameters:
- LEN_W, 8: width of job length and term counter; max job = 2^LEN_W-1 terms.
- OPM_DLY, 2: cycles from driving an operand pair on dsp_a/dsp_b until its OPMODE is driven on dsp_opmode. Matches B0REG+B1REG (A path delayed internally to match) and MREG with OPMODEREG=1.
- RES_DLY, 2: cycles from driving the last OPMODE until dsp_p holds the final sum. Covers OPMODEREG plus PREG.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- start  in  1  job request; accepted only in IDLE
- len  in  LEN_W  number of terms; sampled with start
- abort  in  1  synchronous job cancel
- busy  out  1  high in any state but IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid & in_ready
- in_a  in  18  signed operand A
- in_b  in  18  signed operand B
- dsp_a  out  18  to dsp A
- dsp_b  out  18  to dsp B
- dsp_opmode  out  8  to dsp OPMODE
- dsp_rstp  out  1  to dsp RSTP (sync, active-high)
- dsp_p  in  48  from dsp P
- res_valid  out  1  result valid
- res_ready  in  1  result consumed
- res_data  out  48  signed accumulated sum

Behaviour:
- Reset (RST_N low, async): state IDLE, all outputs 0 except dsp_opmode=HOLD(0x08). Term counter, drain counter and tag pipe are cleared.
- OPMODE constants (bit7=0 add, bit5=0 carry, bit4=0 pre-adder bypass):
  - FIRST=0x01: Z=0, X=M
  - ACC=0x09: Z=P, X=M
  - HOLD=0x08: Z=P, X=0
- States:
  - IDLE: start & len!=0 → ISSUE. Latch len, clear counter, pulse dsp_rstp for 1 cycle. start with len==0 is ignored; stay IDLE.
  - ISSUE: in_ready=1.
    - On accept: drive in_a/in_b on dsp_a/dsp_b next cycle, push tag {valid=1, first=(count==0)}, count++.
    - Cycle with no accept: dsp_a=dsp_b=0, push tag {valid=0}.
    - count reaches len on an accept → DRAIN; in_ready falls the following cycle.
  - DRAIN: in_ready=0, operands 0, bubble tags pushed. Wait exactly OPM_DLY+RES_DLY cycles after the last accept, then register dsp_p into res_data → DONE.
  - DONE: res_valid=1; res_data stable until res_valid&res_ready → IDLE (res_valid low next cycle).
- Tag pipe: OPM_DLY-deep shift of {valid,first}. dsp_opmode is driven from the tag exiting the pipe:
  - valid&first → FIRST
  - valid&!first → ACC
  - !valid → HOLD
- Bubbles (in_valid low mid-job) insert HOLD slots and do not change the sum; the job continues when in_valid returns.
- abort in ISSUE/DRAIN/DONE: next state IDLE, tag pipe flushed, dsp_rstp pulsed 1 cycle, res_valid=0, no result. abort in IDLE has no effect.
- start while busy is ignored. abort and start in the same IDLE cycle: start wins.
- Arithmetic: the sum wraps modulo 2^48; no overflow flag. Products are 36-bit sign-extended by the dsp.
- Throughput: one term/cycle. Job latency = len + OPM_DLY + RES_DLY + 1 cycles from the first accept to res_valid, with no bubbles.

Decomposition:
- Shared package dsp_ctrl_pkg:
  - OPMODE constants FIRST/ACC/HOLD
  - state encoding IDLE/ISSUE/DRAIN/DONE
  - tag struct {valid, first}
- One natural sub-module: dsp_seq_tag_pipe, a parameterized OPM_DLY-deep tag shift register with sync flush.

Test Plan:
- len=3, pairs (2,3),(4,5),(-1,7) back-to-back → res_data=19, res_valid 3+2+2+1=8 cycles after first accept; OPMODE sequence 0x01,0x09,0x09.
- Same job with in_valid low for 2 cycles between pairs 1 and 2 → two HOLD (0x08) slots on dsp_opmode, res_data=19, res_valid 2 cycles later.
- len=2, pairs (-131072,-131072) twice → res_data=0x0008_0000_0000 (2^35).
- res_ready held low 5 cycles in DONE → res_data/res_valid stable. Then a new start issued on the same cycle as the handshake is ignored; one the cycle after the handshake is accepted.
- start with len=0 → busy stays 0, no dsp_rstp. abort mid-ISSUE after 1 of 4 terms → IDLE next cycle, dsp_rstp pulse, no res_valid. A fresh len=1 job (3,3) then gives 9.
- RST_N low mid-DRAIN → all outputs at reset values immediately (async), dsp_opmode=0x08, busy=0.
